// File: rtl/toggle_period_meter_pkg.sv
// Shared definitions for the toggle period meter.
//  - DEF_CNT_W     : default width of the period counter and result
//  - meter_state_e : FSM state encoding (IDLE=0, ARM=1, MEASURE=2, DONE=3)
package toggle_period_meter_pkg;

    localparam int unsigned DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } meter_state_e;

endpackage

// File: rtl/toggle_period_meter_edge_detect.sv
// Registers the signal under test once per clock and flags its edges.
// The register runs in every state so the first rise after arming is
// detected against the true previous level.
//  clk    in  system clock, rising edge
//  reset  in  synchronous active-high reset (previous level forced to 0)
//  din_i  in  signal under test, already synchronous to clk
//  rise_o out din_i high now, low in the previous cycle
//  fall_o out din_i low now, high in the previous cycle
module toggle_period_meter_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din_i,
    output logic rise_o,
    output logic fall_o
);

    logic din_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din_i;
        end
    end

    assign rise_o = din_i & ~din_q;
    assign fall_o = ~din_i & din_q;

endmodule

// File: rtl/toggle_period_meter.sv
// Measures the period of a single-bit periodic signal in clk cycles, from
// one rising edge to the next, and returns it over a valid/ready handshake.
// A measurement that sees no edge within MAX_CNT cycles (while arming or
// while measuring) returns timeout=1 with period=0.
//
// Optional feature: define TOGGLE_METER_HIGH_TIME_EN to also report the
// number of cycles din was high during the measured period on high_cnt.
// Without it high_cnt is constant 0 and no high-time counter is built.
//
// Ports
//  clk        in   system clock, rising edge
//  reset      in   synchronous active-high reset; aborts any measurement
//  din        in   signal under test, synchronous to clk
//  start      in   one-cycle request; only honoured in IDLE
//  busy       out  high whenever the FSM is not IDLE
//  res_valid  out  result available (DONE state)
//  res_ready  in   consumer accepts the result
//  period     out  measured period in cycles, 0 on timeout
//  timeout    out  no edge seen within MAX_CNT cycles
//  high_cnt   out  high cycles within the period (optional feature)
module toggle_period_meter
    import toggle_period_meter_pkg::*;
#(
    parameter int unsigned      CNT_W   = DEF_CNT_W,
    parameter logic [CNT_W-1:0] MAX_CNT = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             start,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] period,
    output logic             timeout,
    output logic [CNT_W-1:0] high_cnt
);

    meter_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             timeout_q, timeout_d;
    logic             rise;
    logic             unused_fall;

`ifdef TOGGLE_METER_HIGH_TIME_EN
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] high_q, high_d;
`endif

    toggle_period_meter_edge_detect u_edge (
        .clk    (clk),
        .reset  (reset),
        .din_i  (din),
        .rise_o (rise),
        .fall_o (unused_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            timeout_q <= 1'b0;
`ifdef TOGGLE_METER_HIGH_TIME_EN
            hcnt_q    <= '0;
            high_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            timeout_q <= timeout_d;
`ifdef TOGGLE_METER_HIGH_TIME_EN
            hcnt_q    <= hcnt_d;
            high_q    <= high_d;
`endif
        end
    end

    // A rise always wins over the limit check, so an edge arriving exactly
    // when cnt reaches MAX_CNT is still measured; the limit is tested before
    // incrementing so cnt never wraps.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        timeout_d = timeout_q;
`ifdef TOGGLE_METER_HIGH_TIME_EN
        hcnt_d    = hcnt_q;
        high_d    = high_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ARM;
                    cnt_d   = '0;
                end
            end
            ST_ARM: begin
                if (rise) begin
                    state_d = ST_MEASURE;
                    cnt_d   = CNT_W'(1);
`ifdef TOGGLE_METER_HIGH_TIME_EN
                    // The arming cycle itself has din=1 and belongs to the period.
                    hcnt_d  = CNT_W'(1);
`endif
                end else if (cnt_q == MAX_CNT) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                    period_d  = '0;
`ifdef TOGGLE_METER_HIGH_TIME_EN
                    high_d    = '0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_MEASURE: begin
                if (rise) begin
                    state_d   = ST_DONE;
                    period_d  = cnt_q;
                    timeout_d = 1'b0;
`ifdef TOGGLE_METER_HIGH_TIME_EN
                    high_d    = hcnt_q;
`endif
                end else if (cnt_q == MAX_CNT) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                    period_d  = '0;
`ifdef TOGGLE_METER_HIGH_TIME_EN
                    high_d    = '0;
`endif
                end else begin
                    cnt_d  = cnt_q + 1'b1;
`ifdef TOGGLE_METER_HIGH_TIME_EN
                    hcnt_d = hcnt_q + CNT_W'(din);
`endif
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign res_valid = (state_q == ST_DONE);
    assign period    = period_q;
    assign timeout   = timeout_q;

`ifdef TOGGLE_METER_HIGH_TIME_EN
    assign high_cnt = high_q;
`else
    assign high_cnt = '0;
`endif

endmodule

// File: tb/tb_toggle_period_meter.sv
// Bench for toggle_period_meter. din follows a per-trial square-wave pattern;
// every sampled din level is logged per clock edge, and the expected result
// (period, timeout, high time, edge of res_valid) is derived by scanning that
// log for rising edges after the accepted start.
module tb_toggle_period_meter;

    localparam int CNT_W = 16;
    localparam int MAX   = 20;
    localparam int HIST  = 8192;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             din = 1'b0;
    logic             start = 1'b0;
    logic             busy;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [CNT_W-1:0] period;
    logic             timeout;
    logic [CNT_W-1:0] high_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pat_h = 0, pat_l = 1, pat_ph = 0;
    logic din_hist [0:HIST-1];
    int last_lat;

    toggle_period_meter #(.CNT_W(CNT_W), .MAX_CNT(16'd20)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .start     (start),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .period    (period),
        .timeout   (timeout),
        .high_cnt  (high_cnt)
    );

    always #5 clk = ~clk;

    // Drive din for the next edge, log the level the DUT will see, advance.
    task automatic step();
        if (pat_h == 0) din = 1'b0;
        else din = (((cyc + 1 + pat_ph) % (pat_h + pat_l)) < pat_h);
        if (cyc + 1 < HIST) din_hist[cyc + 1] = reset ? 1'b0 : din;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic bit is_rise(input int t);
        return din_hist[t] && !din_hist[t - 1];
    endfunction

    // Expected result for a start accepted at edge s.
    function automatic void model(input int s, output int r, output int per,
                                  output bit to, output int hi);
        int t0, t1;
        t0 = -1;
        t1 = -1;
        for (int t = s + 1; t <= s + 1 + MAX; t++)
            if (is_rise(t)) begin t0 = t; break; end
        if (t0 < 0) begin
            r = s + 1 + MAX; per = 0; to = 1'b1; hi = 0;
            return;
        end
        for (int t = t0 + 1; t <= t0 + MAX; t++)
            if (is_rise(t)) begin t1 = t; break; end
        if (t1 < 0) begin
            r = t0 + MAX; per = 0; to = 1'b1; hi = 0;
            return;
        end
        r = t1; per = t1 - t0; to = 1'b0; hi = 0;
`ifdef TOGGLE_METER_HIGH_TIME_EN
        for (int t = t0; t < t1; t++) hi += int'(din_hist[t]);
`endif
    endfunction

    task automatic do_trial(input string name, input int h, input int l, input int ph,
                            input int rdy_delay, input bit poke);
        int s, r, er, eper, ehi;
        bit eto, seen;
        pat_h = h; pat_l = l; pat_ph = ph;
        repeat ($urandom_range(1, 3)) step();
        start = 1'b1;
        step();
        s = cyc;
        start = 1'b0;
        seen = 1'b0;
        r = -1;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (poke && busy) start = 1'($urandom_range(0, 1));
            step();
            start = 1'b0;
            if (res_valid) begin seen = 1'b1; r = cyc; end
        end
        model(s, er, eper, eto, ehi);
        last_lat = r - s;
        checks++;
        if (!seen || r != er) begin
            failures++;
            $display("FAIL %s latency: valid_at=%0d expected=%0d (start=%0d)", name, r, er, s);
            reset = 1'b1; step(); reset = 1'b0;
            return;
        end
        checks++;
        if (period !== CNT_W'(eper) || timeout !== eto || high_cnt !== CNT_W'(ehi) || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s result: period=%0d timeout=%0b high=%0d busy=%0b expected %0d %0b %0d 1",
                     name, period, timeout, high_cnt, busy, eper, eto, ehi);
        end
        for (int i = 0; i < rdy_delay; i++) begin
            if (poke) start = 1'($urandom_range(0, 1));
            step();
            start = 1'b0;
            checks++;
            if (res_valid !== 1'b1 || period !== CNT_W'(eper) || timeout !== eto || high_cnt !== CNT_W'(ehi)) begin
                failures++;
                $display("FAIL %s hold: valid=%0b period=%0d timeout=%0b high=%0d expected 1 %0d %0b %0d",
                         name, res_valid, period, timeout, high_cnt, eper, eto, ehi);
            end
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || period !== CNT_W'(eper) || timeout !== eto) begin
            failures++;
            $display("FAIL %s release: valid=%0b busy=%0b period=%0d timeout=%0b expected 0 0 %0d %0b",
                     name, res_valid, busy, period, timeout, eper, eto);
        end
        $display("trial %s start=%0d valid_at=%0d period=%0d timeout=%0b high=%0d",
                 name, s, r, period, timeout, high_cnt);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || period !== '0 || timeout !== 1'b0 || high_cnt !== '0) begin
            failures++;
            $display("FAIL reset: busy=%0b valid=%0b period=%0d timeout=%0b high=%0d expected all 0",
                     busy, res_valid, period, timeout, high_cnt);
        end
        reset = 1'b0;
        step();
        $display("trial reset busy=%0b valid=%0b", busy, res_valid);
    endtask

    task automatic test_toggle();
        int exp_hi;
`ifdef TOGGLE_METER_HIGH_TIME_EN
        exp_hi = 1;
`else
        exp_hi = 0;
`endif
        do_trial("toggle", 1, 1, 0, 0, 1'b0);
        checks++;
        if (period !== CNT_W'(2) || timeout !== 1'b0 || high_cnt !== CNT_W'(exp_hi) || last_lat < 2) begin
            failures++;
            $display("FAIL toggle_const: period=%0d timeout=%0b high=%0d lat=%0d expected 2 0 %0d",
                     period, timeout, high_cnt, last_lat, exp_hi);
        end
    endtask

    task automatic test_square_4_6();
        int exp_hi;
`ifdef TOGGLE_METER_HIGH_TIME_EN
        exp_hi = 4;
`else
        exp_hi = 0;
`endif
        do_trial("sq4_6", 4, 6, 3, 1, 1'b0);
        checks++;
        if (period !== CNT_W'(10) || timeout !== 1'b0 || high_cnt !== CNT_W'(exp_hi)) begin
            failures++;
            $display("FAIL sq4_6_const: period=%0d timeout=%0b high=%0d expected 10 0 %0d",
                     period, timeout, high_cnt, exp_hi);
        end
    endtask

    task automatic test_timeout();
        do_trial("timeout", 0, 1, 0, 0, 1'b0);
        checks++;
        if (period !== '0 || timeout !== 1'b1 || last_lat != MAX + 1) begin
            failures++;
            $display("FAIL timeout_const: period=%0d timeout=%0b lat=%0d expected 0 1 %0d",
                     period, timeout, last_lat, MAX + 1);
        end
    endtask

    task automatic test_boundaries();
        do_trial("period_max", 10, 10, 5, 0, 1'b0);
        checks++;
        if (period !== CNT_W'(MAX) || timeout !== 1'b0) begin
            failures++;
            $display("FAIL period_max_const: period=%0d timeout=%0b expected %0d 0", period, timeout, MAX);
        end
        do_trial("period_over", 10, 11, 2, 0, 1'b0);
        checks++;
        if (period !== '0 || timeout !== 1'b1) begin
            failures++;
            $display("FAIL period_over_const: period=%0d timeout=%0b expected 0 1", period, timeout);
        end
    endtask

    task automatic test_backpressure();
        do_trial("backpressure", 3, 4, 1, 5, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit bad;
        pat_h = 8; pat_l = 8; pat_ph = 0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (16) step();
        checks++;
        if (busy !== 1'b1 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_pre: busy=%0b valid=%0b expected 1 0", busy, res_valid);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_abort: busy=%0b valid=%0b expected 0 0", busy, res_valid);
        end
        bad = 1'b0;
        repeat (40) begin
            step();
            if (res_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL reset_mid_quiet: valid or busy seen=1 expected 0 after abort");
        end
        $display("trial reset_mid busy=%0b valid=%0b", busy, res_valid);
        do_trial("after_reset", 2, 5, 4, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int results;
        do_trial("start_while_busy", 5, 7, 2, 3, 1'b1);
        results = 0;
        repeat (30) begin
            step();
            if (res_valid === 1'b1 || busy === 1'b1) results++;
        end
        checks++;
        if (results != 0) begin
            failures++;
            $display("FAIL single_result: extra busy/valid cycles=%0d expected 0", results);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            do_trial($sformatf("rand%0d", i), $urandom_range(1, 12), $urandom_range(1, 12),
                     $urandom_range(0, 23), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        din_hist[0] = 1'b0;
        test_reset();
        test_toggle();
        test_square_4_6();
        test_timeout();
        test_boundaries();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
